// File: rtl/rst_pkg.sv
// Shared sizing and entry type for the register status table and its checkpoints.
package rst_pkg;
    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 5;
    localparam int NUM_RD   = 2;
    localparam int NUM_CDB  = 2;
    localparam int NUM_CKPT = 4;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int CK_AW    = $clog2(NUM_CKPT);

    typedef struct packed {
        logic             pending;
        logic [TAG_W-1:0] tag;
    } entry_t;
endpackage

// File: rtl/rst_ckpt_if.sv
// Dispatch/ROB/CDB-facing signal bundle of the register status table.
interface rst_ckpt_if;
    import rst_pkg::*;

    logic [NUM_RD*REG_AW-1:0]  rd_addr;
    logic [NUM_RD*TAG_W-1:0]   rd_tag;
    logic [NUM_RD-1:0]         rd_valid;
    logic                      wen;
    logic [REG_AW-1:0]         waddr;
    logic [TAG_W-1:0]          wtag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic                      ckpt_save;
    logic [CK_AW-1:0]          ckpt_id;
    logic                      ckpt_full;
    logic                      ckpt_restore;
    logic [CK_AW-1:0]          ckpt_rid;
    logic [NUM_CKPT-1:0]       ckpt_release;
    logic                      flush;
    logic [NUM_REGS-1:0]       pending_vec;
    logic                      ckpt_err;

    modport master (
        output rd_addr, wen, waddr, wtag, cdb_valid, cdb_tag,
               ckpt_save, ckpt_restore, ckpt_rid, ckpt_release, flush,
        input  rd_tag, rd_valid, ckpt_id, ckpt_full, pending_vec, ckpt_err
    );

    modport slave (
        input  rd_addr, wen, waddr, wtag, cdb_valid, cdb_tag,
               ckpt_save, ckpt_restore, ckpt_rid, ckpt_release, flush,
        output rd_tag, rd_valid, ckpt_id, ckpt_full, pending_vec, ckpt_err
    );
endinterface

// File: rtl/rst_cdb_match.sv
// Flags every pending entry whose tag is on any valid CDB channel this cycle.
// Purely combinational, no backpressure.
module rst_cdb_match
    import rst_pkg::*;
#(
    parameter int N = NUM_REGS
) (
    input  entry_t [N-1:0]             ent_i,
    input  logic   [NUM_CDB-1:0]       cdb_valid_i,
    input  logic   [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    output logic   [N-1:0]             hit_o
);
    always_comb begin
        hit_o = '0;
        for (int e = 0; e < N; e++) begin
            for (int c = 0; c < NUM_CDB; c++) begin
                if (ent_i[e].pending && cdb_valid_i[c] &&
                    ent_i[e].tag == cdb_tag_i[c*TAG_W +: TAG_W])
                    hit_o[e] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rst_ckpt.sv
// Register status table with CDB clears and branch checkpoints; reads are zero-latency,
// updates land on the next edge, no backpressure (illegal requests pulse ckpt_err instead).
module rst_ckpt
    import rst_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    rst_ckpt_if.slave bus
);
    entry_t [NUM_REGS-1:0]               live_q, live_d, live_clr, live_wr;
    entry_t [NUM_CKPT-1:0][NUM_REGS-1:0] ckpt_q, ckpt_d, ck_clr;
    logic   [NUM_CKPT-1:0]               used_q, used_d, used_rel;
    logic                                err_q, err_d;
    logic   [NUM_REGS-1:0]               live_hit;
    logic   [NUM_CKPT-1:0][NUM_REGS-1:0] ck_hit;
    logic   [CK_AW-1:0]                  free_id;
    logic                                full;

    rst_cdb_match #(.N(NUM_REGS)) u_live_match (
        .ent_i       (live_q),
        .cdb_valid_i (bus.cdb_valid),
        .cdb_tag_i   (bus.cdb_tag),
        .hit_o       (live_hit)
    );

    for (genvar k = 0; k < NUM_CKPT; k++) begin : g_ck_match
        rst_cdb_match #(.N(NUM_REGS)) u_match (
            .ent_i       (ckpt_q[k]),
            .cdb_valid_i (bus.cdb_valid),
            .cdb_tag_i   (bus.cdb_tag),
            .hit_o       (ck_hit[k])
        );
    end

    // Released slots count as free in the same cycle so a save can reuse them.
    always_comb begin
        used_rel = used_q & ~bus.ckpt_release;
        free_id  = '0;
        for (int k = NUM_CKPT-1; k >= 0; k--) begin
            if (!used_rel[k])
                free_id = CK_AW'(k);
        end
        full = &used_rel;
    end

    always_comb begin
        live_clr = live_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (live_hit[r])
                live_clr[r].pending = 1'b0;
        end
        live_wr = live_clr;
        if (bus.wen && bus.waddr != '0)
            live_wr[bus.waddr] = '{pending: 1'b1, tag: bus.wtag};
        ck_clr = ckpt_q;
        for (int k = 0; k < NUM_CKPT; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ck_hit[k][r])
                    ck_clr[k][r].pending = 1'b0;
            end
        end
    end

    always_comb begin
        live_d = live_wr;
        ckpt_d = ck_clr;
        used_d = used_rel;
        err_d  = 1'b0;
        if (bus.flush) begin
            live_d = '0;
            used_d = '0;
        end else if (bus.ckpt_restore) begin
            if (used_q[bus.ckpt_rid]) begin
                live_d                = ck_clr[bus.ckpt_rid];
                used_d[bus.ckpt_rid]  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
            if (bus.ckpt_save)
                err_d = 1'b1;
        end else if (bus.ckpt_save) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                ckpt_d[free_id] = live_wr;
                used_d[free_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            live_q <= '0;
            ckpt_q <= '0;
            used_q <= '0;
            err_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            ckpt_q <= ckpt_d;
            used_q <= used_d;
            err_q  <= err_d;
        end
    end

    assign bus.ckpt_id   = free_id;
    assign bus.ckpt_full = full;
    assign bus.ckpt_err  = err_q;

    always_comb begin
        bus.pending_vec = '0;
        bus.rd_tag      = '0;
        bus.rd_valid    = '0;
        for (int r = 0; r < NUM_REGS; r++)
            bus.pending_vec[r] = live_q[r].pending;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_tag[i*TAG_W +: TAG_W] = live_q[bus.rd_addr[i*REG_AW +: REG_AW]].tag;
            bus.rd_valid[i] = live_q[bus.rd_addr[i*REG_AW +: REG_AW]].pending &
                              ~live_hit[bus.rd_addr[i*REG_AW +: REG_AW]];
        end
    end
endmodule

// File: tb/tb_rst_ckpt.sv
// Directed bench for rst_ckpt: array-based reference model compared every cycle plus literal spot checks.
module tb_rst_ckpt;
    import rst_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rst_ckpt_if bus();
    rst_ckpt dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    int m_pend [NUM_REGS];
    int m_tag  [NUM_REGS];
    int c_pend [NUM_CKPT][NUM_REGS];
    int c_tag  [NUM_CKPT][NUM_REGS];
    bit m_used [NUM_CKPT];
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bcast(input int t);
        for (int c = 0; c < NUM_CDB; c++)
            if (bus.cdb_valid[c] && int'(bus.cdb_tag[c*TAG_W +: TAG_W]) == t)
                return 1'b1;
        return 1'b0;
    endfunction

    // Lowest slot that is unused or being released now; -1 when none.
    function automatic int lowest_free();
        for (int k = 0; k < NUM_CKPT; k++)
            if (!m_used[k] || bus.ckpt_release[k])
                return k;
        return -1;
    endfunction

    task automatic model_update();
        int np [NUM_REGS];
        int nt [NUM_REGS];
        int cp [NUM_CKPT][NUM_REGS];
        int ct [NUM_CKPT][NUM_REGS];
        bit nu [NUM_CKPT];
        int f;
        int rid;
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_pend[r] = 0;
                m_tag[r]  = 0;
            end
            for (int k = 0; k < NUM_CKPT; k++)
                m_used[k] = 1'b0;
            m_err = 1'b0;
            return;
        end
        f   = lowest_free();
        rid = int'(bus.ckpt_rid);
        for (int r = 0; r < NUM_REGS; r++) begin
            np[r] = (m_pend[r] != 0 && bcast(m_tag[r])) ? 0 : m_pend[r];
            nt[r] = m_tag[r];
        end
        for (int k = 0; k < NUM_CKPT; k++) begin
            nu[k] = m_used[k] && !bus.ckpt_release[k];
            for (int r = 0; r < NUM_REGS; r++) begin
                cp[k][r] = (c_pend[k][r] != 0 && bcast(c_tag[k][r])) ? 0 : c_pend[k][r];
                ct[k][r] = c_tag[k][r];
            end
        end
        if (bus.wen && bus.waddr != '0) begin
            np[int'(bus.waddr)] = 1;
            nt[int'(bus.waddr)] = int'(bus.wtag);
        end
        m_err = 1'b0;
        if (bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                np[r] = 0;
                nt[r] = 0;
            end
            for (int k = 0; k < NUM_CKPT; k++)
                nu[k] = 1'b0;
        end else if (bus.ckpt_restore) begin
            if (m_used[rid]) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    np[r] = cp[rid][r];
                    nt[r] = ct[rid][r];
                end
                nu[rid] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            if (bus.ckpt_save)
                m_err = 1'b1;
        end else if (bus.ckpt_save) begin
            if (f < 0) begin
                m_err = 1'b1;
            end else begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cp[f][r] = np[r];
                    ct[f][r] = nt[r];
                end
                nu[f] = 1'b1;
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            m_pend[r] = np[r];
            m_tag[r]  = nt[r];
        end
        for (int k = 0; k < NUM_CKPT; k++) begin
            m_used[k] = nu[k];
            for (int r = 0; r < NUM_REGS; r++) begin
                c_pend[k][r] = cp[k][r];
                c_tag[k][r]  = ct[k][r];
            end
        end
    endtask

    task automatic compare();
        logic [NUM_REGS-1:0] ev;
        int a;
        int f;
        for (int i = 0; i < NUM_RD; i++) begin
            a = int'(bus.rd_addr[i*REG_AW +: REG_AW]);
            chk("cyc_rd_valid", 32'(bus.rd_valid[i]), 32'(m_pend[a] != 0 && !bcast(m_tag[a])));
            if (m_pend[a] != 0)
                chk("cyc_rd_tag", 32'(bus.rd_tag[i*TAG_W +: TAG_W]), 32'(m_tag[a]));
        end
        for (int r = 0; r < NUM_REGS; r++)
            ev[r] = (m_pend[r] != 0);
        chk("cyc_pending_vec", 32'(bus.pending_vec), 32'(ev));
        f = lowest_free();
        chk("cyc_ckpt_full", 32'(bus.ckpt_full), 32'(f < 0));
        if (f >= 0)
            chk("cyc_ckpt_id", 32'(bus.ckpt_id), 32'(f));
        chk("cyc_ckpt_err", 32'(bus.ckpt_err), 32'(m_err));
    endtask

    task automatic step();
        @(negedge clock);
        if (chk_en)
            compare();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.rd_addr      = '0;
        bus.wen          = 1'b0;
        bus.waddr        = '0;
        bus.wtag         = '0;
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.ckpt_save    = 1'b0;
        bus.ckpt_restore = 1'b0;
        bus.ckpt_rid     = '0;
        bus.ckpt_release = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic wr(input int r, input int t);
        bus.wen   = 1'b1;
        bus.waddr = REG_AW'(r);
        bus.wtag  = TAG_W'(t);
    endtask

    task automatic cdb(input int ch, input int t);
        bus.cdb_valid[ch]              = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    task automatic rd(input int p, input int r);
        bus.rd_addr[p*REG_AW +: REG_AW] = REG_AW'(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_pending_vec", 32'(bus.pending_vec), 32'd0);
        chk("rst_ckpt_full", 32'(bus.ckpt_full), 32'd0);
        chk("rst_ckpt_id", 32'(bus.ckpt_id), 32'd0);
        chk("rst_ckpt_err", 32'(bus.ckpt_err), 32'd0);
        chk_en = 1'b1;

        // Basic rename write and r0 immunity.
        idle(); wr(5, 7); step();
        idle(); rd(0, 5); #1;
        chk("t1_rd_valid", 32'(bus.rd_valid[0]), 32'd1);
        chk("t1_rd_tag", 32'(bus.rd_tag[TAG_W-1:0]), 32'd7);
        chk("t1_pend5", 32'(bus.pending_vec[5]), 32'd1);
        wr(0, 3); step();
        idle(); #1;
        chk("t1_r0_never", 32'(bus.pending_vec[0]), 32'd0);

        // One broadcast clears two registers; same-cycle read is masked.
        idle(); wr(9, 7); step();
        idle(); cdb(0, 7); rd(0, 5); rd(1, 9); #1;
        chk("t2_same_cycle_rd_valid", 32'(bus.rd_valid), 32'd0);
        step();
        idle(); #1;
        chk("t2_pend5", 32'(bus.pending_vec[5]), 32'd0);
        chk("t2_pend9", 32'(bus.pending_vec[9]), 32'd0);

        // Write beats clear on the same register.
        idle(); wr(4, 2); step();
        idle(); wr(4, 12); cdb(0, 2); step();
        idle(); rd(0, 4); #1;
        chk("t3_rd_valid", 32'(bus.rd_valid[0]), 32'd1);
        chk("t3_rd_tag", 32'(bus.rd_tag[TAG_W-1:0]), 32'd12);

        // Save, overwrite, clear in checkpoint, restore.
        idle(); wr(3, 4); bus.ckpt_save = 1'b1; #1;
        chk("t4_save_id", 32'(bus.ckpt_id), 32'd0);
        step();
        idle(); wr(3, 9); step();
        idle(); cdb(1, 4); rd(0, 3); step();
        idle(); bus.ckpt_restore = 1'b1; bus.ckpt_rid = '0; wr(6, 1); step();
        idle(); rd(0, 3); rd(1, 4); #1;
        chk("t4_r3_clear", 32'(bus.pending_vec[3]), 32'd0);
        chk("t4_r4_kept", 32'(bus.pending_vec[4]), 32'd1);
        chk("t4_wen_dropped", 32'(bus.pending_vec[6]), 32'd0);
        chk("t4_id", 32'(bus.ckpt_id), 32'd0);
        chk("t4_full", 32'(bus.ckpt_full), 32'd0);

        // Fill all slots, overflow, release, save-with-release, save-with-restore.
        for (int k = 0; k < NUM_CKPT; k++) begin
            idle(); bus.ckpt_save = 1'b1; #1;
            chk("t5_save_id", 32'(bus.ckpt_id), 32'(k));
            step();
        end
        idle(); #1;
        chk("t5_full", 32'(bus.ckpt_full), 32'd1);
        idle(); bus.ckpt_save = 1'b1; wr(10, 3); step();
        idle(); #1;
        chk("t5_err", 32'(bus.ckpt_err), 32'd1);
        chk("t5_still_full", 32'(bus.ckpt_full), 32'd1);
        chk("t5_write_proceeds", 32'(bus.pending_vec[10]), 32'd1);
        idle(); bus.ckpt_release = 4'b0010; step();
        idle(); #1;
        chk("t5_rel_id", 32'(bus.ckpt_id), 32'd1);
        chk("t5_rel_full", 32'(bus.ckpt_full), 32'd0);
        chk("t5_err_cleared", 32'(bus.ckpt_err), 32'd0);
        idle(); bus.ckpt_save = 1'b1; step();
        idle(); bus.ckpt_save = 1'b1; bus.ckpt_release = 4'b0001; #1;
        chk("t5_rel_save_id", 32'(bus.ckpt_id), 32'd0);
        step();
        idle(); #1;
        chk("t5_rel_save_err", 32'(bus.ckpt_err), 32'd0);
        chk("t5_rel_save_full", 32'(bus.ckpt_full), 32'd1);
        idle(); bus.ckpt_release = 4'b0100; step();
        idle(); bus.ckpt_save = 1'b1; bus.ckpt_restore = 1'b1; bus.ckpt_rid = '0; step();
        idle(); #1;
        chk("t5_save_restore_err", 32'(bus.ckpt_err), 32'd1);
        chk("t5_save_restore_id", 32'(bus.ckpt_id), 32'd0);
        idle(); bus.ckpt_save = 1'b1; step();
        idle(); #1;
        chk("t5_slot2_free", 32'(bus.ckpt_id), 32'd2);

        // Restore of a free slot; the write still happens.
        idle(); bus.ckpt_restore = 1'b1; bus.ckpt_rid = CK_AW'(2); wr(7, 5); step();
        idle(); #1;
        chk("t6_err", 32'(bus.ckpt_err), 32'd1);
        chk("t6_write_kept", 32'(bus.pending_vec[7]), 32'd1);
        chk("t6_id", 32'(bus.ckpt_id), 32'd2);

        // Flush overrides everything else, silently.
        idle(); bus.flush = 1'b1; wr(8, 3); bus.ckpt_save = 1'b1;
        bus.ckpt_restore = 1'b1; bus.ckpt_rid = '0; step();
        idle(); #1;
        chk("t6_flush_pending", 32'(bus.pending_vec), 32'd0);
        chk("t6_flush_full", 32'(bus.ckpt_full), 32'd0);
        chk("t6_flush_id", 32'(bus.ckpt_id), 32'd0);
        chk("t6_flush_err", 32'(bus.ckpt_err), 32'd0);

        // Two channels clear at once; checkpointed entries are cleared too.
        for (int r = 1; r <= 6; r++) begin
            idle(); wr(r, r); step();
        end
        idle(); cdb(0, 2); cdb(1, 5); rd(0, 2); rd(1, 5); step();
        idle(); #1;
        chk("t7_multi_clear", 32'(bus.pending_vec[6:1]), 32'b101101);
        idle(); bus.ckpt_save = 1'b1; step();
        idle(); cdb(0, 1); cdb(1, 3); rd(0, 1); rd(1, 3); step();
        idle(); wr(1, 9); step();
        idle(); bus.ckpt_restore = 1'b1; bus.ckpt_rid = '0; step();
        idle(); #1;
        chk("t7_ckpt_cleared", 32'(bus.pending_vec[6:1]), 32'b101000);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
